sysid_checker: RTL

- Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = build timestamp) and compares both words against expected values.
- Sits directly upstream of the system-ID slave's control port, on the bring-up/boot path.
- Gives host logic and LEDs a pass/fail verdict before the acquisition datapath is enabled.
- Mismatches are retried a bounded number of times; a stalled slave is detected by a timeout.

---
 rtl/sysid_checker_if.sv | 29 ++
 rtl/sysid_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sysid_checker_if.sv
// rtl/sysid_checker_if.sv - Avalon-MM read bus between sysid_checker and the system-ID slave
//
// Signals:
//   avm_address      0 = ID word, 1 = build timestamp word
//   avm_read         read strobe, held with address while avm_waitrequest=1
//   avm_readdata     slave read data (32 bits)
//   avm_waitrequest  slave stall
// Modports: master (checker side), slave (system-ID side).

interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - boot-time reader/comparator of the system-ID slave
//
// Reads word 0 (ID) and word 1 (build timestamp) from the system-ID slave and
// compares them with EXPECTED_ID / EXPECTED_TS. A mismatch reruns the whole
// read/compare pass up to RETRY_LIMIT extra times; a read stalled for TIMEOUT
// consecutive waitrequest cycles aborts the check without retry.
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   start          one-cycle request, honoured only when idle
//   avm            Avalon-MM master (sysid_checker_if.master)
//   busy           check in progress
//   done           one-cycle pulse when a check ends
//   pass / fail    sticky verdict of the last check
//   timeout        sticky: last failure was a stalled read
//   id_value       last captured ID word
//   ts_value       last captured timestamp word
//   attempts       passes used by the last check

module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h0000_0000,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter int          RETRY_LIMIT  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value,
    output logic [3:0]             attempts
);

    typedef enum logic [2:0] {
        IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, COMPARE, FINISH
    } state_t;

    localparam bit ZERO_LAT = (READ_LATENCY == 0);

    state_t      state, state_nx;
    logic [15:0] wait_cnt;
    logic [1:0]  lat_cnt;

    logic in_rd, accept, stall_expired, lat_last, match, retry, start_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        avm.avm_read    = 1'b0;
        avm.avm_address = 1'b0;
        in_rd           = (state == RD_ID) || (state == RD_TS);
        accept          = in_rd && !avm.avm_waitrequest;
        // The stall that would make the count reach TIMEOUT aborts the read.
        stall_expired   = in_rd && avm.avm_waitrequest && (wait_cnt == 16'(TIMEOUT - 1));
        lat_last        = !ZERO_LAT && (lat_cnt == 2'(READ_LATENCY - 1));
        match           = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        retry           = {1'b0, attempts} <= 5'(RETRY_LIMIT);
        // A start arriving during the done pulse is not taken.
        start_ok        = start && !done;

        case (state)
            IDLE:    if (start_ok) state_nx = RD_ID;
            RD_ID: begin
                avm.avm_read = 1'b1;
                if (stall_expired)  state_nx = FINISH;
                else if (accept)    state_nx = ZERO_LAT ? RD_TS : LAT_ID;
            end
            LAT_ID:  if (lat_last) state_nx = RD_TS;
            RD_TS: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b1;
                if (stall_expired)  state_nx = FINISH;
                else if (accept)    state_nx = ZERO_LAT ? COMPARE : LAT_TS;
            end
            LAT_TS:  if (lat_last) state_nx = COMPARE;
            COMPARE: state_nx = (!match && retry) ? RD_ID : FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
            attempts <= '0;
            wait_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            // done lands on the edge after FINISH, together with busy falling.
            done     <= (state == FINISH);
            wait_cnt <= '0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        timeout  <= 1'b0;
                        attempts <= 4'd1;
                        busy     <= 1'b1;
                    end
                end
                RD_ID, RD_TS: begin
                    if (avm.avm_waitrequest) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (stall_expired) begin
                            fail    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= '0;
                        if (ZERO_LAT) begin
                            if (state == RD_ID) id_value <= avm.avm_readdata;
                            else                ts_value <= avm.avm_readdata;
                        end
                    end
                end
                LAT_ID, LAT_TS: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_last) begin
                        if (state == LAT_ID) id_value <= avm.avm_readdata;
                        else                 ts_value <= avm.avm_readdata;
                    end
                end
                COMPARE: begin
                    if (match)      pass     <= 1'b1;
                    else if (retry) attempts <= attempts + 4'd1;
                    else            fail     <= 1'b1;
                end
                FINISH:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
